// File: rtl/gpio_sw_debounce_pkg.sv
// Shared GPIO switch constants used by the switch debouncer and its bus interface.
package gpio_sw_debounce_pkg;

    localparam int unsigned GPIO_SW_WIDTH                = 16;
    localparam int unsigned GPIO_DEBOUNCE_CYCLES_DEFAULT = 100000;

endpackage : gpio_sw_debounce_pkg

// File: rtl/gpio_sw_debounce_if.sv
// Switch-conditioning bus between board pins / GPIO peripheral (master) and the debouncer (slave).
interface gpio_sw_debounce_if
    import gpio_sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH = GPIO_SW_WIDTH
);

    logic             bypass_i;
    logic [WIDTH-1:0] sw_raw_i;
    logic [WIDTH-1:0] sw_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             change_o;

    modport master (
        output bypass_i,
        output sw_raw_i,
        input  sw_o,
        input  rise_o,
        input  fall_o,
        input  change_o
    );

    modport slave (
        input  bypass_i,
        input  sw_raw_i,
        output sw_o,
        output rise_o,
        output fall_o,
        output change_o
    );

endinterface : gpio_sw_debounce_if

// File: rtl/gpio_debounce_bit.sv
// Single switch bit: synchroniser, consecutive-stability counter, accepted level and edge pulses.
module gpio_debounce_bit #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic bypass,
    input  logic swRaw,
    output logic sw,
    output logic rise,
    output logic fall,
    output logic pulseNext_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : gBadSyncStages
        $error("gpio_debounce_bit: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : gBadDebounceCycles
        $error("gpio_debounce_bit: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] syncQ;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cntNext;
    logic                   stableNext;
    logic                   riseNext;
    logic                   fallNext;
    logic                   synced;

    assign synced = syncQ[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ <= '0;
            cnt   <= '0;
            sw    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], swRaw};
            cnt   <= cntNext;
            sw    <= stableNext;
            rise  <= riseNext;
            fall  <= fallNext;
        end
    end

    // Acceptance: a differing level must survive DEBOUNCE_CYCLES consecutive edges; bypass accepts at once.
    always_comb begin
        cntNext    = cnt;
        stableNext = sw;
        riseNext   = 1'b0;
        fallNext   = 1'b0;

        if (bypass) begin
            cntNext    = '0;
            stableNext = synced;
        end else if (synced == sw) begin
            cntNext = '0;
        end else if (cnt == LAST_CNT) begin
            cntNext    = '0;
            stableNext = synced;
        end else begin
            cntNext = cnt + CNT_W'(1);
        end

        if (stableNext != sw) begin
            riseNext = stableNext;
            fallNext = ~stableNext;
        end
    end

    assign pulseNext_c = riseNext | fallNext;

endmodule : gpio_debounce_bit

// File: rtl/gpio_sw_debounce.sv
// Debounces the board switch pins for the GPIO peripheral and flags any accepted change.
module gpio_sw_debounce
    import gpio_sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = GPIO_SW_WIDTH,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    gpio_sw_debounce_if.slave  bus
);

    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pulseNext_c;
    logic             change;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : gBit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) uBit (
            .clk         (clk),
            .rst         (rst),
            .bypass      (bus.bypass_i),
            .swRaw       (bus.sw_raw_i[i]),
            .sw          (sw[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .pulseNext_c (pulseNext_c[i])
        );
    end

    // Registered from the next-cycle pulses so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            change <= 1'b0;
        end else begin
            change <= |pulseNext_c;
        end
    end

    assign bus.sw_o     = sw;
    assign bus.rise_o   = rise;
    assign bus.fall_o   = fall;
    assign bus.change_o = change;

endmodule : gpio_sw_debounce

// File: tb/tb_gpio_sw_debounce.sv
// Bench for gpio_sw_debounce: directed scenarios plus random stimulus against a sample-window model.
module tb_gpio_sw_debounce;

    localparam int unsigned W  = 16;
    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;

    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    gpio_sw_debounce_if #(.WIDTH(W)) bus ();

    gpio_sw_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks = 0;
    int nPass   = 0;
    int changeSeen = 0;
    int riseSeen   = 0;
    int fallSeen   = 0;

    // Model: synchroniser delay line plus a window of the last DC synced samples.
    logic [W-1:0] mSync [SS];
    logic [W-1:0] hSynced [$];
    bit           hElig   [$];
    logic [W-1:0] expSw, expRise, expFall;
    logic         expChange;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic void modelEdge();
        logic [W-1:0] synced;
        logic [W-1:0] newSw;
        bit           ok;
        if (rst) begin
            for (int i = 0; i < int'(SS); i++) mSync[i] = '0;
            expSw = '0; expRise = '0; expFall = '0; expChange = 1'b0;
            hSynced.delete();
            hElig.delete();
            return;
        end
        synced = mSync[SS-1];
        for (int i = int'(SS) - 1; i > 0; i--) mSync[i] = mSync[i-1];
        mSync[0] = bus.sw_raw_i;
        hSynced.push_back(synced);
        hElig.push_back(!bus.bypass_i);
        if (hSynced.size() > int'(DC)) begin
            void'(hSynced.pop_front());
            void'(hElig.pop_front());
        end
        newSw = expSw;
        for (int b = 0; b < int'(W); b++) begin
            if (bus.bypass_i) begin
                newSw[b] = synced[b];
            end else if (hSynced.size() == int'(DC)) begin
                ok = 1'b1;
                for (int j = 0; j < int'(DC); j++)
                    if (!hElig[j] || hSynced[j][b] == expSw[b]) ok = 1'b0;
                if (ok) newSw[b] = synced[b];
            end
        end
        expRise   = newSw & ~expSw;
        expFall   = ~newSw & expSw;
        expChange = |(expRise | expFall);
        expSw     = newSw;
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkVal({tag, " sw"},     32'(bus.sw_o),     32'(expSw));
        checkVal({tag, " rise"},   32'(bus.rise_o),   32'(expRise));
        checkVal({tag, " fall"},   32'(bus.fall_o),   32'(expFall));
        checkVal({tag, " change"}, 32'(bus.change_o), 32'(expChange));
        if (bus.change_o) changeSeen++;
        riseSeen += $countones(bus.rise_o);
        fallSeen += $countones(bus.fall_o);
    endtask

    task automatic hold(input logic [W-1:0] val, input int n, input string tag);
        bus.sw_raw_i = val;
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    initial begin
        logic [W-1:0] rv;
        int           len;

        rst = 1'b1;
        bus.bypass_i = 1'b0;
        bus.sw_raw_i = '0;
        tick("reset");
        tick("reset");
        checkVal("reset sw",     32'(bus.sw_o),     32'h0);
        checkVal("reset pulses", 32'(bus.rise_o | bus.fall_o), 32'h0);
        checkVal("reset change", 32'(bus.change_o), 32'h0);

        // Clean step: accepted after the sixth edge from the step.
        rst = 1'b0;
        bus.sw_raw_i = 16'h0001;
        for (int k = 0; k < 6; k++) begin
            tick("step");
            checkVal("step sw",   32'(bus.sw_o),   (k == 5) ? 32'h1 : 32'h0);
            checkVal("step rise", 32'(bus.rise_o), (k == 5) ? 32'h1 : 32'h0);
        end
        tick("step after");
        checkVal("step rise gone", 32'(bus.rise_o), 32'h0);

        // Glitch of three cycles is rejected; a long hold is accepted.
        hold(16'h0009, 3, "glitch");
        hold(16'h0001, 8, "glitch low");
        checkVal("glitch sw3", 32'(bus.sw_o[3]), 32'h0);
        hold(16'h0009, 8, "long hold");
        checkVal("long hold sw3", 32'(bus.sw_o[3]), 32'h1);

        // Full release.
        hold(16'hFFFF, 8, "all high");
        bus.sw_raw_i = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            tick("release");
            checkVal("release fall", 32'(bus.fall_o), (k == 5) ? 32'hFFFF : 32'h0);
        end
        checkVal("release sw", 32'(bus.sw_o), 32'h0);

        // Bypass: bit 7 toggles every three cycles.
        bus.bypass_i = 1'b1;
        riseSeen = 0;
        fallSeen = 0;
        for (int s = 0; s < 6; s++) hold((s % 2 == 0) ? 16'h0080 : 16'h0000, 3, "bypass");
        hold(16'h0000, 2, "bypass tail");
        checkVal("bypass rises", 32'(riseSeen), 32'd3);
        checkVal("bypass falls", 32'(fallSeen), 32'd3);
        bus.bypass_i = 1'b0;

        // Reset mid-count discards the partial count.
        hold(16'h0010, 3, "pre reset");
        rst = 1'b1;
        tick("mid reset");
        checkVal("mid reset sw", 32'(bus.sw_o), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick("after reset");
            checkVal("after reset sw", 32'(bus.sw_o), (k == 5) ? 32'h10 : 32'h0);
        end

        // Independent bits two cycles apart.
        hold(16'h0000, 8, "indep settle");
        changeSeen = 0;
        hold(16'h0001, 2, "indep b0");
        hold(16'h0003, 8, "indep b1");
        checkVal("indep changes", 32'(changeSeen), 32'd2);

        // Random segments with occasional bypass and reset.
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 3))
                0:       rv = W'($urandom);
                1:       rv = bus.sw_raw_i ^ (W'(1) << $urandom_range(0, W - 1));
                default: rv = bus.sw_raw_i ^ (W'($urandom) & W'($urandom));
            endcase
            len = $urandom_range(1, 8);
            bus.bypass_i = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            bus.sw_raw_i = rv;
            tick("random");
            rst = 1'b0;
            hold(rv, len - 1, "random");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule : tb_gpio_sw_debounce
